// File: rtl/hw_mailbox_arbiter_if.sv
// Bundle of the shared mailbox port: per-requester command side plus the single
// downstream command/response port toward the mailbox FSM.
interface hw_mailbox_arbiter_if #(
    parameter int P_NO_REQ     = 2,
    parameter int P_ADDR_WIDTH = 4,
    parameter int P_DATA_WIDTH = 32
);
    logic [P_NO_REQ-1:0]                   req_lock;
    logic [P_NO_REQ-1:0]                   req_do_read;
    logic [P_NO_REQ-1:0]                   req_do_write;
    logic [P_NO_REQ-1:0][P_ADDR_WIDTH-1:0] req_address;
    logic [P_NO_REQ-1:0][P_DATA_WIDTH-1:0] req_data_wr;
    logic [P_NO_REQ-1:0]                   grant;
    logic [P_NO_REQ-1:0]                   req_ready;
    logic [P_DATA_WIDTH-1:0]               req_data_rd;

    logic                                  m_do_read;
    logic                                  m_do_write;
    logic [P_ADDR_WIDTH-1:0]               m_address;
    logic [P_DATA_WIDTH-1:0]               m_data_wr;
    logic                                  m_ready;
    logic [P_DATA_WIDTH-1:0]               m_data_rd;

    // Arbiter view: consumes requester strobes and mailbox responses.
    modport slave (
        input  req_lock, req_do_read, req_do_write, req_address, req_data_wr,
        input  m_ready, m_data_rd,
        output grant, req_ready, req_data_rd,
        output m_do_read, m_do_write, m_address, m_data_wr
    );

    // Environment view: requesters plus the downstream mailbox FSM.
    modport master (
        output req_lock, req_do_read, req_do_write, req_address, req_data_wr,
        output m_ready, m_data_rd,
        input  grant, req_ready, req_data_rd,
        input  m_do_read, m_do_write, m_address, m_data_wr
    );
endinterface

// File: rtl/hw_mailbox_arbiter.sv
// Round-robin lock arbiter sharing one mailbox command/response port between
// P_NO_REQ requesters, with a watchdog that reclaims the port from a stalled owner.
module hw_mailbox_arbiter #(
    parameter int P_NO_REQ         = 2,
    parameter int P_ADDR_WIDTH     = 4,
    parameter int P_DATA_WIDTH     = 32,
    parameter int P_TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        reset,
    hw_mailbox_arbiter_if.slave         bus,
    output logic                        timeout_err,
    output logic [$clog2(P_NO_REQ)-1:0] timeout_id
);
    localparam int IDX_W = $clog2(P_NO_REQ);
    localparam int WD_W  = $clog2(P_TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(P_TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_NO_REQ - 1);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(P_NO_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWNED,
        S_RELEASE
    } state_t;

    state_t                 state_reg, state_next;
    logic [P_NO_REQ-1:0]    grant_reg, grant_next;
    logic [IDX_W-1:0]       owner_reg, owner_next;
    logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [WD_W-1:0]        wd_cnt_reg, wd_cnt_next;
    logic                   timeout_err_reg, timeout_err_next;
    logic [IDX_W-1:0]       timeout_id_reg, timeout_id_next;

    logic [IDX_W-1:0]       owner_inc;
    logic [IDX_W-1:0]       arb_base;
    logic [2*P_NO_REQ-1:0]  lock_rot;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_off;
    logic [IDX_W:0]         pick_sum;
    logic [IDX_W-1:0]       pick_idx;
    logic [P_NO_REQ-1:0]    pick_onehot;

    logic [P_NO_REQ-1:0]    ready_lane;
    logic [P_NO_REQ-1:0]    rd_lane;
    logic [P_NO_REQ-1:0]    wr_lane;
    logic                   owned;
    logic                   owner_strobe;

    assign owner_inc = (owner_reg == IDX_LAST) ? '0 : owner_reg + 1'b1;

    // Arbitrating from S_RELEASE with the already-rotated pointer keeps the
    // gap between owners at exactly one cycle.
    assign arb_base = (state_reg == S_RELEASE) ? owner_inc : rr_ptr_reg;
    assign lock_rot = {bus.req_lock, bus.req_lock} >> arb_base;

    always_comb begin
        pick_valid = 1'b0;
        pick_off   = '0;
        for (int i = P_NO_REQ - 1; i >= 0; i--) begin
            if (lock_rot[i]) begin
                pick_valid = 1'b1;
                pick_off   = IDX_W'(i);
            end
        end
    end

    assign pick_sum    = {1'b0, arb_base} + {1'b0, pick_off};
    assign pick_idx    = (pick_sum >= N_EXT) ? IDX_W'(pick_sum - N_EXT) : IDX_W'(pick_sum);
    assign pick_onehot = {{(P_NO_REQ-1){1'b0}}, 1'b1} << pick_idx;

    // Only the owner's lane is enabled; grant is zero outside S_OWNED, so the
    // downstream port is quiet in idle and in the release gap.
    for (genvar gi = 0; gi < P_NO_REQ; gi++) begin : g_lane
        assign ready_lane[gi] = grant_reg[gi] & bus.m_ready;
        assign rd_lane[gi]    = grant_reg[gi] & bus.req_do_read[gi];
        assign wr_lane[gi]    = grant_reg[gi] & bus.req_do_write[gi];
    end

    assign owned           = |grant_reg;
    assign bus.grant       = grant_reg;
    assign bus.req_ready   = ready_lane;
    assign bus.req_data_rd = bus.m_data_rd;
    assign bus.m_do_read   = |rd_lane;
    assign bus.m_do_write  = |wr_lane;
    assign bus.m_address   = owned ? bus.req_address[owner_reg] : '0;
    assign bus.m_data_wr   = owned ? bus.req_data_wr[owner_reg] : '0;
    assign owner_strobe    = (|rd_lane) | (|wr_lane);

    assign timeout_err = timeout_err_reg;
    assign timeout_id  = timeout_id_reg;

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        owner_next       = owner_reg;
        rr_ptr_next      = rr_ptr_reg;
        wd_cnt_next      = wd_cnt_reg;
        timeout_err_next = 1'b0;
        timeout_id_next  = timeout_id_reg;

        case (state_reg)
            S_IDLE: begin
                if (pick_valid) begin
                    state_next  = S_OWNED;
                    grant_next  = pick_onehot;
                    owner_next  = pick_idx;
                    wd_cnt_next = '0;
                end
            end
            S_OWNED: begin
                if (owner_strobe) begin
                    wd_cnt_next = '0;
                end else if (wd_cnt_reg != WD_LAST) begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
                // Both exits wait for m_ready so an in-flight op always completes.
                if (!bus.req_lock[owner_reg] && bus.m_ready) begin
                    state_next = S_RELEASE;
                    grant_next = '0;
                end else if ((wd_cnt_reg == WD_LAST) && bus.m_ready) begin
                    state_next       = S_RELEASE;
                    grant_next       = '0;
                    timeout_err_next = 1'b1;
                    timeout_id_next  = owner_reg;
                end
            end
            S_RELEASE: begin
                rr_ptr_next = owner_inc;
                if (pick_valid) begin
                    state_next  = S_OWNED;
                    grant_next  = pick_onehot;
                    owner_next  = pick_idx;
                    wd_cnt_next = '0;
                end else begin
                    state_next = S_IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            grant_reg       <= '0;
            owner_reg       <= '0;
            rr_ptr_reg      <= '0;
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
            timeout_id_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            owner_reg       <= owner_next;
            rr_ptr_reg      <= rr_ptr_next;
            wd_cnt_reg      <= wd_cnt_next;
            timeout_err_reg <= timeout_err_next;
            timeout_id_reg  <= timeout_id_next;
        end
    end
endmodule

// File: tb/tb_hw_mailbox_arbiter.sv
// Directed bench for hw_mailbox_arbiter: two requesters, 16-cycle watchdog,
// expected values hand-derived per step.
module tb_hw_mailbox_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic reset;
    logic timeout_err;
    logic timeout_id;

    int checks = 0;
    int errors = 0;

    hw_mailbox_arbiter_if #(.P_NO_REQ(NREQ), .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) bus_if ();

    hw_mailbox_arbiter #(
        .P_NO_REQ(NREQ), .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if.slave),
        .timeout_err(timeout_err),
        .timeout_id(timeout_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        $display("check %-16s obs=%0h exp=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        reset                = 1'b1;
        bus_if.req_lock      = '0;
        bus_if.req_do_read   = '0;
        bus_if.req_do_write  = '0;
        bus_if.req_address   = '0;
        bus_if.req_data_wr   = '0;
        bus_if.m_ready       = 1'b1;
        bus_if.m_data_rd     = 32'hA5A5_0001;
        tick(); tick(); tick();

        // Reset state
        check("rst_grant",    bus_if.grant, 0);
        check("rst_terr",     timeout_err, 0);
        check("rst_tid",      timeout_id, 0);
        check("rst_m_rd",     bus_if.m_do_read, 0);
        check("rst_m_wr",     bus_if.m_do_write, 0);
        check("rst_m_addr",   bus_if.m_address, 0);
        check("rst_ready",    bus_if.req_ready, 0);
        check("rst_data_rd",  bus_if.req_data_rd, 32'hA5A5_0001);
        reset = 1'b0;

        // Single requester 0: one-cycle grant latency and pass-through
        bus_if.req_lock       = 2'b01;
        bus_if.req_address[0] = 4'h3;
        bus_if.req_address[1] = 4'hC;
        bus_if.req_data_wr[0] = 32'h1111_1111;
        bus_if.req_data_wr[1] = 32'hDEAD_BEEF;
        #1;
        check("t1_pre_grant", bus_if.grant, 0);
        tick();
        check("t1_grant",     bus_if.grant, 2'b01);
        check("t1_addr",      bus_if.m_address, 4'h3);
        check("t1_ready",     bus_if.req_ready, 2'b01);
        bus_if.req_address[0] = 4'h5;
        #1;
        check("t1_addr_track", bus_if.m_address, 4'h5);
        bus_if.req_do_write[1] = 1'b1;
        #1;
        check("t1_nonown_wr", bus_if.m_do_write, 0);
        check("t1_nonown_dat", bus_if.m_data_wr, 32'h1111_1111);
        bus_if.m_data_rd = 32'h0BAD_F00D;
        #1;
        check("t1_data_rd",   bus_if.req_data_rd, 32'h0BAD_F00D);
        bus_if.req_do_write[1] = 1'b0;
        bus_if.req_do_write[0] = 1'b1;
        #1;
        check("t1_own_wr",    bus_if.m_do_write, 1);
        bus_if.req_do_write[0] = 1'b0;
        bus_if.req_lock = 2'b00;
        tick();
        check("t1_release",   bus_if.grant, 0);
        check("t1_rel_addr",  bus_if.m_address, 0);
        tick();
        check("t1_idle",      bus_if.grant, 0);

        // Simultaneous locks after reset: 0 first, one gap cycle, then 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_if.req_lock = 2'b11;
        tick();
        check("t2_first",     bus_if.grant, 2'b01);
        bus_if.req_lock = 2'b10;
        tick();
        check("t2_gap",       bus_if.grant, 2'b00);
        tick();
        check("t2_second",    bus_if.grant, 2'b10);
        check("t2_ready",     bus_if.req_ready, 2'b10);
        bus_if.req_lock = 2'b00;
        tick();
        check("t2_rel",       bus_if.grant, 2'b00);
        tick();
        bus_if.req_lock = 2'b11;
        tick();
        check("t2_rr_wrap",   bus_if.grant, 2'b01);

        // Lock dropped while m_ready low: grant holds until m_ready rises
        bus_if.m_ready  = 1'b0;
        bus_if.req_lock = 2'b10;
        #1;
        check("t3_ready_low", bus_if.req_ready, 2'b00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold",  bus_if.grant, 2'b01);
        end
        bus_if.m_ready = 1'b1;
        #1;
        check("t3_ready_rise", bus_if.req_ready, 2'b01);
        tick();
        check("t3_released",  bus_if.grant, 2'b00);
        tick();
        check("t3_next",      bus_if.grant, 2'b10);
        bus_if.req_lock = 2'b00;
        tick();
        tick();

        // Idle owner 1 times out on its 16th owned cycle, then is re-granted
        bus_if.req_lock = 2'b10;
        tick();
        check("t4_grant",     bus_if.grant, 2'b10);
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            check("t4_hold",  bus_if.grant, 2'b10);
            check("t4_no_terr", timeout_err, 0);
        end
        tick();
        check("t4_tmo_grant", bus_if.grant, 2'b00);
        check("t4_tmo_err",   timeout_err, 1);
        check("t4_tmo_id",    timeout_id, 1);
        tick();
        check("t4_err_pulse", timeout_err, 0);
        check("t4_regrant",   bus_if.grant, 2'b10);
        check("t4_id_sticky", timeout_id, 1);

        // Reset while the owner has a read on the bus
        bus_if.req_do_read[1] = 1'b1;
        #1;
        check("t5_m_rd",      bus_if.m_do_read, 1);
        check("t5_m_addr",    bus_if.m_address, 4'hC);
        reset = 1'b1;
        tick();
        check("t5_grant",     bus_if.grant, 0);
        check("t5_m_rd_off",  bus_if.m_do_read, 0);
        check("t5_m_addr_off", bus_if.m_address, 0);
        check("t5_tid",       timeout_id, 0);
        bus_if.req_do_read = '0;
        bus_if.req_lock    = '0;
        reset = 1'b0;
        tick();
        check("t5_idle",      bus_if.grant, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
